// File: rtl/mod_counter_cascade_if.sv
// Control and status bundle for mod_counter_cascade.
//   master: drives en, up_dn, clr, load, load_val, cmp_val;
//           observes cnt, tc, wrap, ovf_sticky, match.
//   slave : the counter side, the mirror image of master.
// Packed vectors hold digit k at bits [k*DIGIT_W +: DIGIT_W].
interface mod_counter_cascade_if #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DIGIT_W = 4
);
    logic                      en;
    logic                      up_dn;
    logic                      clr;
    logic                      load;
    logic [DIGITS*DIGIT_W-1:0] load_val;
    logic [DIGITS*DIGIT_W-1:0] cmp_val;
    logic [DIGITS*DIGIT_W-1:0] cnt;
    logic                      tc;
    logic                      wrap;
    logic                      ovf_sticky;
    logic                      match;

    modport master (
        output en, up_dn, clr, load, load_val, cmp_val,
        input  cnt, tc, wrap, ovf_sticky, match
    );

    modport slave (
        input  en, up_dn, clr, load, load_val, cmp_val,
        output cnt, tc, wrap, ovf_sticky, match
    );
endinterface

// File: rtl/mod_counter_cascade.sv
// Multi-digit cascaded modulo counter (BCD by default) with clear, parallel load,
// terminal count, wrap pulse, sticky overflow and compare-match.
//   clk  : clock, rising edge
//   rstn : synchronous active-low reset
//   bus  : slave side of mod_counter_cascade_if
//          en/up_dn step control, clr, load/load_val, cmp_val in;
//          cnt, tc (comb), wrap (registered pulse), ovf_sticky, match (comb) out.
// Edge priority: rstn low > clr > load > en.
module mod_counter_cascade #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MODULUS = 10
) (
    input logic                  clk,
    input logic                  rstn,
    mod_counter_cascade_if.slave bus
);

    typedef logic [DIGITS-1:0][DIGIT_W-1:0] digits_t;

    localparam logic [DIGIT_W-1:0] DigitMax = DIGIT_W'(MODULUS - 1);

    digits_t cnt_q, cnt_d;
    digits_t load_digits;
    logic    wrap_q, wrap_d;
    logic    ovf_q, ovf_d;
    logic    all_max, all_zero;

    assign load_digits = bus.load_val;

    always_comb begin : p_flags
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (cnt_q[k] != DigitMax) all_max  = 1'b0;
            if (cnt_q[k] != '0)       all_zero = 1'b0;
        end
    end

    always_comb begin : p_next
        logic chain; // carry (up) or borrow (down) entering digit k
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        chain  = 1'b0;
        if (bus.clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            // Out-of-range digits saturate so the digit invariant survives a load.
            for (int k = 0; k < DIGITS; k++) begin
                cnt_d[k] = (load_digits[k] > DigitMax) ? DigitMax : load_digits[k];
            end
        end else if (bus.en) begin
            chain = 1'b1;
            for (int k = 0; k < DIGITS; k++) begin
                if (chain) begin
                    if (bus.up_dn) begin
                        if (cnt_q[k] == DigitMax) begin
                            cnt_d[k] = '0;
                        end else begin
                            cnt_d[k] = cnt_q[k] + 1'b1;
                            chain    = 1'b0;
                        end
                    end else begin
                        if (cnt_q[k] == '0) begin
                            cnt_d[k] = DigitMax;
                        end else begin
                            cnt_d[k] = cnt_q[k] - 1'b1;
                            chain    = 1'b0;
                        end
                    end
                end
            end
            // A chain surviving the top digit means every digit rolled over.
            wrap_d = chain;
            ovf_d  = ovf_q | chain;
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (!rstn) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.cnt        = cnt_q;
    assign bus.wrap       = wrap_q;
    assign bus.ovf_sticky = ovf_q;
    assign bus.tc         = bus.en && ((bus.up_dn && all_max) || (!bus.up_dn && all_zero));
    // Stored digits are always in range, so an out-of-range cmp_val digit cannot match.
    assign bus.match      = (cnt_q == bus.cmp_val);

endmodule

// File: tb/tb_mod_counter_cascade.sv
// Directed bench for mod_counter_cascade: a default BCD 4-digit instance and a
// 1-digit modulo-2 instance sharing one clock and reset.
module tb_mod_counter_cascade;

    logic clk;
    logic rstn;
    int   total;
    int   passes;

    mod_counter_cascade_if #(.DIGITS(4), .DIGIT_W(4)) bus_a ();
    mod_counter_cascade_if #(.DIGITS(1), .DIGIT_W(1)) bus_b ();

    mod_counter_cascade #(.DIGITS(4), .DIGIT_W(4), .MODULUS(10)) u_dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_a)
    );

    mod_counter_cascade #(.DIGITS(1), .DIGIT_W(1), .MODULUS(2)) u_dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        total  = 0;
        passes = 0;
        rstn   = 1'b0;
        bus_a.en = 1'b0; bus_a.up_dn = 1'b1; bus_a.clr = 1'b0; bus_a.load = 1'b0;
        bus_a.load_val = 16'h0000; bus_a.cmp_val = 16'h0010;
        bus_b.en = 1'b0; bus_b.up_dn = 1'b1; bus_b.clr = 1'b0; bus_b.load = 1'b0;
        bus_b.load_val = 1'b0; bus_b.cmp_val = 1'b1;
        @(negedge clk);
        step();
        chk("rst_cnt", 32'(bus_a.cnt), 32'h0);
        chk("rst_wrap", 32'(bus_a.wrap), 32'h0);
        chk("rst_ovf", 32'(bus_a.ovf_sticky), 32'h0);

        // 1: ten up-steps from zero
        rstn = 1'b1; bus_a.en = 1'b1; bus_a.up_dn = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            chk("up_cnt", 32'(bus_a.cnt), (n < 10) ? 32'(n) : 32'h0010);
            if (n >= 9) begin
                chk("up_match", 32'(bus_a.match), (n == 10) ? 32'h1 : 32'h0);
                chk("up_tc", 32'(bus_a.tc), 32'h0);
            end
        end

        // 2: up-wrap from 9998
        bus_a.load = 1'b1; bus_a.load_val = 16'h9998;
        step();
        chk("ld_cnt", 32'(bus_a.cnt), 32'h9998);
        bus_a.load = 1'b0;
        step();
        chk("up9999_cnt", 32'(bus_a.cnt), 32'h9999);
        chk("up9999_tc", 32'(bus_a.tc), 32'h1);
        chk("up9999_wrap", 32'(bus_a.wrap), 32'h0);
        step();
        chk("upwrap_cnt", 32'(bus_a.cnt), 32'h0000);
        chk("upwrap_wrap", 32'(bus_a.wrap), 32'h1);
        chk("upwrap_ovf", 32'(bus_a.ovf_sticky), 32'h1);
        step();
        chk("postwrap_cnt", 32'(bus_a.cnt), 32'h0001);
        chk("postwrap_wrap", 32'(bus_a.wrap), 32'h0);
        chk("postwrap_ovf", 32'(bus_a.ovf_sticky), 32'h1);

        // 3: clear, then down-wrap
        bus_a.en = 1'b0; bus_a.clr = 1'b1;
        step();
        chk("clr_cnt", 32'(bus_a.cnt), 32'h0);
        chk("clr_ovf", 32'(bus_a.ovf_sticky), 32'h0);
        bus_a.clr = 1'b0; bus_a.en = 1'b1; bus_a.up_dn = 1'b0;
        #1;
        chk("dn0_tc", 32'(bus_a.tc), 32'h1);
        step();
        chk("dnwrap_cnt", 32'(bus_a.cnt), 32'h9999);
        chk("dnwrap_wrap", 32'(bus_a.wrap), 32'h1);
        chk("dnwrap_ovf", 32'(bus_a.ovf_sticky), 32'h1);
        step();
        chk("dn9998_cnt", 32'(bus_a.cnt), 32'h9998);
        chk("dn9998_wrap", 32'(bus_a.wrap), 32'h0);
        chk("dn9998_ovf", 32'(bus_a.ovf_sticky), 32'h1);
        bus_a.clr = 1'b1;
        step();
        chk("clr2_cnt", 32'(bus_a.cnt), 32'h0);
        chk("clr2_ovf", 32'(bus_a.ovf_sticky), 32'h0);
        // From zero counting down, a wrap would be due; clr on the same edge must win.
        step();
        chk("clrwin_cnt", 32'(bus_a.cnt), 32'h0);
        chk("clrwin_wrap", 32'(bus_a.wrap), 32'h0);
        chk("clrwin_ovf", 32'(bus_a.ovf_sticky), 32'h0);

        // 4: clamped load, same-cycle en ignored
        bus_a.clr = 1'b0; bus_a.load = 1'b1; bus_a.load_val = 16'hF0A5; bus_a.up_dn = 1'b1;
        bus_a.cmp_val = 16'h9095;
        step();
        chk("clamp_cnt", 32'(bus_a.cnt), 32'h9095);
        chk("clamp_wrap", 32'(bus_a.wrap), 32'h0);
        chk("clamp_match", 32'(bus_a.match), 32'h1);
        bus_a.cmp_val = 16'hF0A5;
        #1;
        chk("oor_match", 32'(bus_a.match), 32'h0);
        bus_a.load = 1'b0; bus_a.en = 1'b0;
        step();
        chk("hold_cnt", 32'(bus_a.cnt), 32'h9095);

        // 5: multi-digit borrow, load keeps ovf, reset mid-count
        bus_a.load = 1'b1; bus_a.load_val = 16'h1000;
        step();
        bus_a.load = 1'b0; bus_a.en = 1'b1; bus_a.up_dn = 1'b0;
        step();
        chk("borrow_cnt", 32'(bus_a.cnt), 32'h0999);
        bus_a.load = 1'b1; bus_a.load_val = 16'h0000;
        step();
        bus_a.load = 1'b0;
        step();
        chk("dnwrap2_ovf", 32'(bus_a.ovf_sticky), 32'h1);
        bus_a.load = 1'b1; bus_a.load_val = 16'h0040;
        step();
        chk("ldkeep_ovf", 32'(bus_a.ovf_sticky), 32'h1);
        chk("ldkeep_wrap", 32'(bus_a.wrap), 32'h0);
        bus_a.load = 1'b0; bus_a.up_dn = 1'b1;
        step();
        step();
        chk("to42_cnt", 32'(bus_a.cnt), 32'h0042);
        rstn = 1'b0;
        step();
        chk("rstmid_cnt", 32'(bus_a.cnt), 32'h0);
        chk("rstmid_wrap", 32'(bus_a.wrap), 32'h0);
        chk("rstmid_ovf", 32'(bus_a.ovf_sticky), 32'h0);
        bus_a.load = 1'b1; bus_a.load_val = 16'h1234;
        step();
        chk("rstld_cnt", 32'(bus_a.cnt), 32'h0);
        rstn = 1'b1; bus_a.load = 1'b0; bus_a.en = 1'b0;

        // 6: one digit, modulus 2
        bus_b.en = 1'b1; bus_b.up_dn = 1'b1;
        step();
        chk("m2_c1", 32'(bus_b.cnt), 32'h1);
        chk("m2_w1", 32'(bus_b.wrap), 32'h0);
        chk("m2_tc1", 32'(bus_b.tc), 32'h1);
        step();
        chk("m2_c2", 32'(bus_b.cnt), 32'h0);
        chk("m2_w2", 32'(bus_b.wrap), 32'h1);
        chk("m2_ovf", 32'(bus_b.ovf_sticky), 32'h1);
        step();
        chk("m2_c3", 32'(bus_b.cnt), 32'h1);
        chk("m2_w3", 32'(bus_b.wrap), 32'h0);
        step();
        chk("m2_c4", 32'(bus_b.cnt), 32'h0);
        chk("m2_w4", 32'(bus_b.wrap), 32'h1);
        step();
        chk("m2_c5", 32'(bus_b.cnt), 32'h1);
        bus_b.en = 1'b0; bus_b.clr = 1'b1; bus_b.load = 1'b1; bus_b.load_val = 1'b1;
        step();
        chk("m2_clrld_cnt", 32'(bus_b.cnt), 32'h0);
        chk("m2_clrld_ovf", 32'(bus_b.ovf_sticky), 32'h0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
